// File: rtl/prng_pkg.sv
// Shared widths, FSM state encoding and default timeout for the seed path into prng_gen.
package prng_pkg;
   localparam int WORD_W = 64;
   localparam int BYTE_W = 8;
   localparam int TIMEOUT_CYCLES_DEF = 1000000;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;
endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter: counts while run=1, saturates at TIMEOUT_CYCLES-1, cleared by clear.
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_reg <= '0;
      else if (clear)
         count_reg <= '0;
      else if (run && (count_reg != LAST))
         count_reg <= count_reg + 1'b1;
   end

   // Only asserted in a cycle with no byte; the owner clears the count the same edge.
   assign expired = run && (count_reg == LAST);
endmodule

// File: rtl/uart_seed_assembler.sv
// Packs NUM_BYTES received UART bytes into a 64-bit word for prng_gen; partial words are
// dropped on inter-byte timeout or framing error so the host can always resynchronise.
module uart_seed_assembler
   import prng_pkg::*;
#(
   parameter int NUM_BYTES      = 8,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter bit MSB_FIRST      = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] rx_byte,
   input  logic              rx_byte_valid,
   input  logic              rx_frame_err,
   output logic [WORD_W-1:0] data_out,
   output logic              word_valid,
   output logic              busy,
   output logic [3:0]        byte_count,
   output logic              drop_pulse
);
   localparam logic [3:0] LAST_COUNT = 4'(NUM_BYTES - 1);

   state_t            state_reg, state_next;
   logic [WORD_W-1:0] sr_reg, sr_next, sr_shift;
   logic [WORD_W-1:0] data_out_reg, data_out_next;
   logic [3:0]        count_reg, count_next;
   logic              word_valid_reg, word_valid_next;
   logic              drop_reg, drop_next;
   logic              timer_clear, timer_run, timer_expired;

   assign sr_shift = MSB_FIRST ? {sr_reg[WORD_W-BYTE_W-1:0], rx_byte}
                               : {rx_byte, sr_reg[WORD_W-1:BYTE_W]};

   // A byte in the expiry cycle stops the timer from running, so the byte wins.
   assign timer_run   = (state_reg == ST_COLLECT) && !rx_byte_valid;
   assign timer_clear = (state_reg != ST_COLLECT) || rx_byte_valid || rx_frame_err
                        || timer_expired;

   idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .run    (timer_run),
      .expired(timer_expired)
   );

   always_comb begin
      state_next      = state_reg;
      sr_next         = sr_reg;
      count_next      = count_reg;
      data_out_next   = data_out_reg;
      word_valid_next = 1'b0;
      drop_next       = 1'b0;

      // Framing error beats a simultaneous byte; the byte goes with the partial word.
      if (rx_frame_err || ((state_reg == ST_COLLECT) && timer_expired)) begin
         drop_next  = 1'b1;
         sr_next    = '0;
         count_next = '0;
         state_next = ST_IDLE;
      end else if (rx_byte_valid) begin
         if (count_reg == LAST_COUNT) begin
            data_out_next   = sr_shift;
            word_valid_next = 1'b1;
            sr_next         = '0;
            count_next      = '0;
            state_next      = ST_IDLE;
         end else begin
            sr_next    = sr_shift;
            count_next = count_reg + 4'd1;
            state_next = ST_COLLECT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         sr_reg         <= '0;
         count_reg      <= '0;
         data_out_reg   <= '0;
         word_valid_reg <= 1'b0;
         drop_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sr_reg         <= sr_next;
         count_reg      <= count_next;
         data_out_reg   <= data_out_next;
         word_valid_reg <= word_valid_next;
         drop_reg       <= drop_next;
      end
   end

   assign data_out   = data_out_reg;
   assign word_valid = word_valid_reg;
   assign busy       = (state_reg == ST_COLLECT);
   assign byte_count = count_reg;
   assign drop_pulse = drop_reg;
endmodule
